// File: rtl/serial_receive.sv
// Serial-to-parallel receiver: start(1), 8 data bits LSB first, stop bit, into a FWFT FIFO.
// Optional stop-bit checking is enabled by defining RX_FRAME_CHECK_EN.
module serial_receive #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       SerData,
    input  logic       RdEn,
    output logic [7:0] DataOut,
    output logic       Empty,
    output logic       Full,
    output logic       FrameErr,
    output logic       Overrun
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_STOP
    } state_t;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          overrun_q;

    logic stop_ok;
    logic push;
    logic pop;
    logic accept;

`ifdef RX_FRAME_CHECK_EN
    logic frame_err_q;
    assign stop_ok  = SerData;
    assign FrameErr = frame_err_q;
`else
    assign stop_ok  = 1'b1;
    assign FrameErr = 1'b0;
`endif

    // A push into a full FIFO still succeeds when the head is popped on the same edge.
    always_comb begin
        push    = (state_q == ST_STOP) && stop_ok;
        pop     = RdEn && (count_q != '0);
        accept  = push && ((count_q != CNT_FULL) || pop);
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        Empty   = (count_q == '0);
        Full    = (count_q == CNT_FULL);
        DataOut = Empty ? '0 : mem_q[rd_ptr_q];
        Overrun = overrun_q;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef RX_FRAME_CHECK_EN
            frame_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (SerData) begin
                        state_q   <= ST_DATA;
                        bit_cnt_q <= '0;
                    end
                end
                ST_DATA: begin
                    shift_q[bit_cnt_q] <= SerData;
                    bit_cnt_q          <= bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_q <= ST_STOP;
                    end
                end
                ST_STOP: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase

            if (accept) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            count_q   <= count_d;
            overrun_q <= push && !accept;
`ifdef RX_FRAME_CHECK_EN
            frame_err_q <= (state_q == ST_STOP) && !SerData;
`endif
        end
    end

endmodule

// File: tb/tb_serial_receive.sv
// Directed bench for serial_receive: queue-based reference model checked every cycle
// plus literal expectations at key points of each scenario.
module tb_serial_receive;

    localparam int unsigned DEPTH = 4;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       SerData;
    logic       RdEn;
    logic [7:0] DataOut;
    logic       Empty;
    logic       Full;
    logic       FrameErr;
    logic       Overrun;

    serial_receive #(.DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .SerData  (SerData),
        .RdEn     (RdEn),
        .DataOut  (DataOut),
        .Empty    (Empty),
        .Full     (Full),
        .FrameErr (FrameErr),
        .Overrun  (Overrun)
    );

    always #5 Clk = ~Clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] model_q[$];
    bit         exp_ferr = 1'b0;
    bit         exp_ovr  = 1'b0;
    bit         cmp_en   = 1'b0;

    function automatic void chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endfunction

    // Compare process: model says what every output must be in each cycle.
    always @(negedge Clk) begin
        if (cmp_en && !Reset) begin
            chk("cyc_dataout", DataOut, (model_q.size() > 0) ? model_q[0] : 8'h00);
            chk("cyc_empty", {7'b0, Empty}, {7'b0, (model_q.size() == 0)});
            chk("cyc_full", {7'b0, Full}, {7'b0, (model_q.size() == DEPTH)});
            chk("cyc_frameerr", {7'b0, FrameErr}, {7'b0, exp_ferr});
            chk("cyc_overrun", {7'b0, Overrun}, {7'b0, exp_ovr});
        end
    end

    // One clock: drive inputs, take the edge, apply the same edge to the model.
    task automatic tick(input logic ser, input logic rd, input bit stop_evt, input logic [7:0] b);
        bit do_push;
        SerData = ser;
        RdEn    = rd;
        @(posedge Clk);
        #1;
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        if (rd && model_q.size() > 0) void'(model_q.pop_front());
        if (stop_evt) begin
`ifdef RX_FRAME_CHECK_EN
            do_push  = ser;
            exp_ferr = !ser;
`else
            do_push = 1'b1;
`endif
            if (do_push) begin
                if (model_q.size() == DEPTH) exp_ovr = 1'b1;
                else model_q.push_back(b);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopbit, input logic rd_on_stop);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 8; i++) tick(b[i], 1'b0, 1'b0, 8'h00);
        tick(stopbit, rd_on_stop, 1'b1, b);
    endtask

    logic [7:0] pop_exp [4];

    initial begin
        pop_exp[0] = 8'h80;
        pop_exp[1] = 8'hFF;
        pop_exp[2] = 8'h00;
        pop_exp[3] = 8'h77;
        Reset   = 1'b1;
        SerData = 1'b0;
        RdEn    = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_dataout", DataOut, 8'h00);
        chk("rst_empty", {7'b0, Empty}, 8'h01);
        chk("rst_full", {7'b0, Full}, 8'h00);
        chk("rst_frameerr", {7'b0, FrameErr}, 8'h00);
        chk("rst_overrun", {7'b0, Overrun}, 8'h00);
        Reset  = 1'b0;
        cmp_en = 1'b1;

        tick(1'b0, 1'b0, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'hA5, 1'b1, 1'b0);
        chk("a5_dataout", DataOut, 8'hA5);
        chk("a5_empty", {7'b0, Empty}, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        chk("a5_pop_dataout", DataOut, 8'h00);
        chk("a5_pop_empty", {7'b0, Empty}, 8'h01);

        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0);
        chk("b2b_full", {7'b0, Full}, 8'h01);
        chk("b2b_head", DataOut, 8'h01);

        send_frame(8'h77, 1'b1, 1'b0);
        chk("ovr_pulse", {7'b0, Overrun}, 8'h01);
        chk("ovr_head", DataOut, 8'h01);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ovr_clear", {7'b0, Overrun}, 8'h00);

        send_frame(8'h77, 1'b1, 1'b1);
        chk("pushpop_overrun", {7'b0, Overrun}, 8'h00);
        chk("pushpop_full", {7'b0, Full}, 8'h01);
        for (int i = 0; i < 4; i++) begin
            chk("drain_order", DataOut, pop_exp[i]);
            tick(1'b0, 1'b1, 1'b0, 8'h00);
        end
        chk("drain_empty", {7'b0, Empty}, 8'h01);

        send_frame(8'h3C, 1'b0, 1'b0);
`ifdef RX_FRAME_CHECK_EN
        chk("ferr_pulse", {7'b0, FrameErr}, 8'h01);
        chk("ferr_empty", {7'b0, Empty}, 8'h01);
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        chk("ferr_clear", {7'b0, FrameErr}, 8'h00);
`else
        chk("nochk_dataout", DataOut, 8'h3C);
        chk("nochk_frameerr", {7'b0, FrameErr}, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
`endif

        send_frame(8'h11, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) tick(((i >= 4) ? 1'b1 : 1'b0), 1'b0, 1'b0, 8'h00);
        Reset = 1'b1;
        #1;
        chk("midrst_dataout", DataOut, 8'h00);
        chk("midrst_empty", {7'b0, Empty}, 8'h01);
        chk("midrst_full", {7'b0, Full}, 8'h00);
        model_q.delete();
        exp_ferr = 1'b0;
        exp_ovr  = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'h5A, 1'b1, 1'b0);
        chk("postrst_dataout", DataOut, 8'h5A);
        chk("postrst_empty", {7'b0, Empty}, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 8'h00);

        // StartOp sampled at edge T: the transmitter's start bit is sampled at T+1.
        tick(1'b0, 1'b0, 1'b0, 8'h00);
        send_frame(8'hC3, 1'b1, 1'b0);
        chk("loop_dataout", DataOut, 8'hC3);
        chk("loop_frameerr", {7'b0, FrameErr}, 8'h00);
        chk("loop_overrun", {7'b0, Overrun}, 8'h00);
        tick(1'b0, 1'b1, 1'b0, 8'h00);
        tick(1'b0, 1'b0, 1'b0, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
